// File: rtl/stepper_position_tracker.sv
// Multi-axis step-pulse position tracker.
// Counts synchronised step edges per axis into signed position registers. Each axis has
// load-over-step priority, wrap or saturate overflow handling, registered soft-limit flags
// and sticky error flags. A snapshot request captures a coherent copy of all axes.
module stepper_position_tracker #(
   parameter int unsigned N_AXES      = 5,
   parameter int unsigned POS_W       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          SATURATE    = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_AXES-1:0]         stepper_enable,
   input  logic [N_AXES-1:0]         stepper_step,
   input  logic [N_AXES-1:0]         stepper_direction,
   input  logic [N_AXES-1:0]         set_new_coordinates,
   input  logic [N_AXES*POS_W-1:0]   new_pos,
   input  logic [N_AXES*POS_W-1:0]   lim_min,
   input  logic [N_AXES*POS_W-1:0]   lim_max,
   input  logic                      clear_flags,
   input  logic                      snap_req,
   output logic [N_AXES*POS_W-1:0]   pos,
   output logic [N_AXES-1:0]         at_min,
   output logic [N_AXES-1:0]         at_max,
   output logic [N_AXES-1:0]         step_lost,
   output logic [N_AXES-1:0]         overflow,
   output logic                      snap_valid,
   output logic [N_AXES*POS_W-1:0]   snap_pos
);

   localparam int unsigned IN_W = 3 * N_AXES;
   localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

   logic [IN_W-1:0]         raw_in;
   logic [IN_W-1:0]         synced;
   logic [N_AXES-1:0]       s_step, s_direction, s_enable;
   logic [N_AXES-1:0]       step_prev_q;
   logic [N_AXES-1:0]       step_edge;
   logic [N_AXES*POS_W-1:0] pos_d, pos_q;
   logic [N_AXES-1:0]       step_lost_d, step_lost_q;
   logic [N_AXES-1:0]       overflow_d, overflow_q;
   logic [N_AXES-1:0]       at_min_q, at_max_q;
   logic                    snap_valid_q;
   logic [N_AXES*POS_W-1:0] snap_pos_q;

   assign raw_in = {stepper_enable, stepper_direction, stepper_step};

   // Step, direction and enable share one chain so they stay aligned stage for stage
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign synced = raw_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
         // Shift raw inputs through the synchroniser flops
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= raw_in;
               for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end
         assign synced = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign s_step      = synced[N_AXES-1:0];
   assign s_direction = synced[2*N_AXES-1:N_AXES];
   assign s_enable    = synced[3*N_AXES-1:2*N_AXES];
   assign step_edge   = s_step & ~step_prev_q;

   // Next position and sticky flags; a load beats a step, a set beats a clear
   always_comb begin
      pos_d       = pos_q;
      step_lost_d = step_lost_q & ~{N_AXES{clear_flags}};
      overflow_d  = overflow_q & ~{N_AXES{clear_flags}};
      for (int unsigned i = 0; i < N_AXES; i++) begin
         if (set_new_coordinates[i]) begin
            pos_d[i*POS_W +: POS_W] = new_pos[i*POS_W +: POS_W];
            if (step_edge[i]) begin
               step_lost_d[i] = 1'b1;
            end
         end else if (step_edge[i] && !s_enable[i]) begin
            if (!s_direction[i]) begin
               if (pos_q[i*POS_W +: POS_W] == POS_MAX) begin
                  overflow_d[i]           = 1'b1;
                  pos_d[i*POS_W +: POS_W] = SATURATE ? POS_MAX : POS_MIN;
               end else begin
                  pos_d[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] + POS_ONE;
               end
            end else begin
               if (pos_q[i*POS_W +: POS_W] == POS_MIN) begin
                  overflow_d[i]           = 1'b1;
                  pos_d[i*POS_W +: POS_W] = SATURATE ? POS_MIN : POS_MAX;
               end else begin
                  pos_d[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] - POS_ONE;
               end
            end
         end
      end
   end

   // Position, flag, edge-detect and snapshot state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q        <= '0;
         step_lost_q  <= '0;
         overflow_q   <= '0;
         step_prev_q  <= '0;
         snap_valid_q <= 1'b0;
         snap_pos_q   <= '0;
      end else begin
         pos_q        <= pos_d;
         step_lost_q  <= step_lost_d;
         overflow_q   <= overflow_d;
         step_prev_q  <= s_step;
         snap_valid_q <= snap_req;
         // Capture the post-update value so the copy matches pos after this edge
         if (snap_req) begin
            snap_pos_q <= pos_d;
         end
      end
   end

   // Limit flags compare the registered position, so they lag pos by one clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         at_min_q <= '0;
         at_max_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N_AXES; i++) begin
            at_min_q[i] <= $signed(pos_q[i*POS_W +: POS_W]) <= $signed(lim_min[i*POS_W +: POS_W]);
            at_max_q[i] <= $signed(pos_q[i*POS_W +: POS_W]) >= $signed(lim_max[i*POS_W +: POS_W]);
         end
      end
   end

   assign pos        = pos_q;
   assign at_min     = at_min_q;
   assign at_max     = at_max_q;
   assign step_lost  = step_lost_q;
   assign overflow   = overflow_q;
   assign snap_valid = snap_valid_q;
   assign snap_pos   = snap_pos_q;

endmodule

// File: tb/tb_stepper_position_tracker.sv
// Bench for stepper_position_tracker: a wrapping and a saturating instance share stimulus
// and are compared against an integer-arithmetic reference model of the tracker.
module tb_stepper_position_tracker;
   localparam int NA   = 5;
   localparam int PW   = 8;
   localparam int SS   = 2;
   localparam int PMAX = 127;
   localparam int PMIN = -128;

   typedef int arr_t[NA];
   typedef struct packed {logic [NA-1:0] st; logic [NA-1:0] di; logic [NA-1:0] en;} samp_t;

   logic clk = 1'b0;
   logic reset;
   logic [NA-1:0] stepper_enable, stepper_step, stepper_direction, set_new_coordinates;
   logic [NA*PW-1:0] new_pos, lim_min, lim_max;
   logic clear_flags, snap_req;
   logic [NA*PW-1:0] pos, snap_pos, pos_s, snap_pos_s;
   logic [NA-1:0] at_min, at_max, step_lost, overflow;
   logic [NA-1:0] at_min_s, at_max_s, step_lost_s, overflow_s;
   logic snap_valid, snap_valid_s;

   int errors, checks;

   // reference model state
   samp_t hist[$];
   arr_t m_pos, m_sat, m_snap, m_snap_sat;
   logic [NA-1:0] m_lost, m_ovf, m_ovf_s, m_amin, m_amax, m_amin_s, m_amax_s;
   logic m_sv;

   always #5 clk = ~clk;

   stepper_position_tracker #(.N_AXES(NA), .POS_W(PW), .SYNC_STAGES(SS), .SATURATE(1'b0)) dut (
      .clk(clk), .reset(reset), .stepper_enable(stepper_enable), .stepper_step(stepper_step),
      .stepper_direction(stepper_direction), .set_new_coordinates(set_new_coordinates),
      .new_pos(new_pos), .lim_min(lim_min), .lim_max(lim_max), .clear_flags(clear_flags),
      .snap_req(snap_req), .pos(pos), .at_min(at_min), .at_max(at_max),
      .step_lost(step_lost), .overflow(overflow), .snap_valid(snap_valid), .snap_pos(snap_pos)
   );

   stepper_position_tracker #(.N_AXES(NA), .POS_W(PW), .SYNC_STAGES(SS), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .stepper_enable(stepper_enable), .stepper_step(stepper_step),
      .stepper_direction(stepper_direction), .set_new_coordinates(set_new_coordinates),
      .new_pos(new_pos), .lim_min(lim_min), .lim_max(lim_max), .clear_flags(clear_flags),
      .snap_req(snap_req), .pos(pos_s), .at_min(at_min_s), .at_max(at_max_s),
      .step_lost(step_lost_s), .overflow(overflow_s), .snap_valid(snap_valid_s),
      .snap_pos(snap_pos_s)
   );

   function automatic logic [NA*PW-1:0] pack(input arr_t v);
      logic [NA*PW-1:0] r;
      r = '0;
      for (int i = 0; i < NA; i++) r[i*PW +: PW] = v[i][PW-1:0];
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (SS + 2) hist.push_front('0);
      for (int i = 0; i < NA; i++) begin
         m_pos[i] = 0; m_sat[i] = 0; m_snap[i] = 0; m_snap_sat[i] = 0;
      end
      m_lost = '0; m_ovf = '0; m_ovf_s = '0;
      m_amin = '0; m_amax = '0; m_amin_s = '0; m_amax_s = '0;
      m_sv = 1'b0;
   endtask

   // One clock edge of the specified behaviour: inputs seen SS edges late, loads immediate.
   task automatic model_edge();
      samp_t cur, s, p;
      int d, n, lo, hi, np;
      cur.st = stepper_step; cur.di = stepper_direction; cur.en = stepper_enable;
      hist.push_front(cur);
      void'(hist.pop_back());
      s = hist[SS];
      p = hist[SS+1];
      for (int i = 0; i < NA; i++) begin
         lo = $signed(lim_min[i*PW +: PW]);
         hi = $signed(lim_max[i*PW +: PW]);
         np = $signed(new_pos[i*PW +: PW]);
         m_amin[i] = m_pos[i] <= lo;  m_amax[i] = m_pos[i] >= hi;
         m_amin_s[i] = m_sat[i] <= lo; m_amax_s[i] = m_sat[i] >= hi;
         if (clear_flags) begin
            m_lost[i] = 1'b0; m_ovf[i] = 1'b0; m_ovf_s[i] = 1'b0;
         end
         if (set_new_coordinates[i]) begin
            m_pos[i] = np; m_sat[i] = np;
            if (s.st[i] && !p.st[i]) m_lost[i] = 1'b1;
         end else if (s.st[i] && !p.st[i] && !s.en[i]) begin
            d = s.di[i] ? -1 : 1;
            n = m_pos[i] + d;
            if (n > PMAX) begin n = PMIN; m_ovf[i] = 1'b1; end
            if (n < PMIN) begin n = PMAX; m_ovf[i] = 1'b1; end
            m_pos[i] = n;
            n = m_sat[i] + d;
            if (n > PMAX) begin n = PMAX; m_ovf_s[i] = 1'b1; end
            if (n < PMIN) begin n = PMIN; m_ovf_s[i] = 1'b1; end
            m_sat[i] = n;
         end
      end
      if (snap_req) begin
         m_snap = m_pos; m_snap_sat = m_sat;
      end
      m_sv = snap_req;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic pulse(input int ax, input logic dir, input int n);
      stepper_direction[ax] = dir;
      repeat (SS + 1) tick();
      for (int k = 0; k < n; k++) begin
         stepper_step[ax] = 1'b1; tick();
         stepper_step[ax] = 1'b0; tick();
      end
      repeat (SS + 1) tick();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({pos, pos_s, snap_pos, snap_pos_s} !== '0) begin
         errors++; $display("FAIL reset_pos: got %h want 0", {pos, pos_s, snap_pos, snap_pos_s});
      end
      checks++;
      if ({at_min, at_max, step_lost, overflow, snap_valid, at_min_s, at_max_s, step_lost_s,
           overflow_s, snap_valid_s} !== '0) begin
         errors++; $display("FAIL reset_flags: got %h want 0", {at_min, at_max, step_lost,
                            overflow, snap_valid, at_min_s, at_max_s, step_lost_s, overflow_s,
                            snap_valid_s});
      end
      reset = 1'b0;
      model_reset();
      tick();
      checks++;
      if (at_min !== m_amin || at_max !== m_amax) begin
         errors++; $display("FAIL reset_first_limits: got %b/%b want %b/%b", at_min, at_max,
                            m_amin, m_amax);
      end
   endtask

   task automatic test_count();
      logic [NA*PW-1:0] e;
      stepper_direction[1] = 1'b0;
      repeat (SS + 1) tick();
      stepper_step[1] = 1'b1;
      tick();
      tick();
      checks++;
      if (pos[PW +: PW] !== 8'd0) begin
         errors++; $display("FAIL count_latency_early: got %0d want 0", pos[PW +: PW]);
      end
      tick();
      checks++;
      if (pos[PW +: PW] !== 8'd1) begin
         errors++; $display("FAIL count_latency: got %0d want 1", pos[PW +: PW]);
      end
      stepper_step[1] = 1'b0;
      tick();
      pulse(1, 1'b0, 9);
      pulse(1, 1'b1, 3);
      e = '0;
      e[PW +: PW] = 8'd7;
      checks++;
      if (pos !== e) begin errors++; $display("FAIL count_pos: got %h want %h", pos, e); end
      checks++;
      if (pos_s !== pack(m_sat)) begin
         errors++; $display("FAIL count_pos_sat: got %h want %h", pos_s, pack(m_sat));
      end
   endtask

   task automatic test_enable();
      stepper_enable[2] = 1'b1;
      pulse(2, 1'b0, 5);
      checks++;
      if (pos[2*PW +: PW] !== 8'd0) begin
         errors++; $display("FAIL enable_gated: got %0d want 0", pos[2*PW +: PW]);
      end
      stepper_enable[2] = 1'b0;
      pulse(2, 1'b0, 5);
      checks++;
      if (pos[2*PW +: PW] !== 8'd5) begin
         errors++; $display("FAIL enable_counted: got %0d want 5", pos[2*PW +: PW]);
      end
   endtask

   task automatic test_collision();
      stepper_step[0] = 1'b1;
      tick(); tick();
      set_new_coordinates[0] = 1'b1;
      new_pos[0 +: PW] = 8'd100;
      tick();
      set_new_coordinates[0] = 1'b0;
      stepper_step[0] = 1'b0;
      repeat (3) tick();
      checks++;
      if (pos[0 +: PW] !== 8'd100 || step_lost[0] !== 1'b1) begin
         errors++; $display("FAIL collision: got pos=%0d lost=%b want 100/1", pos[0 +: PW],
                            step_lost[0]);
      end
      checks++;
      if (step_lost !== m_lost || step_lost_s !== m_lost) begin
         errors++; $display("FAIL collision_lost: got %b/%b want %b", step_lost, step_lost_s,
                            m_lost);
      end
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      checks++;
      if (step_lost[0] !== 1'b0) begin
         errors++; $display("FAIL collision_clear: got %b want 0", step_lost[0]);
      end
   endtask

   task automatic test_overflow();
      set_new_coordinates[4] = 1'b1;
      new_pos[4*PW +: PW] = 8'd127;
      tick();
      set_new_coordinates[4] = 1'b0;
      checks++;
      if (overflow[4] !== 1'b0 || overflow_s[4] !== 1'b0) begin
         errors++; $display("FAIL overflow_load: got %b/%b want 0/0", overflow[4], overflow_s[4]);
      end
      pulse(4, 1'b0, 1);
      checks++;
      if (pos[4*PW +: PW] !== 8'h80 || overflow[4] !== 1'b1) begin
         errors++; $display("FAIL overflow_wrap: got %h/%b want 80/1", pos[4*PW +: PW],
                            overflow[4]);
      end
      checks++;
      if (pos_s[4*PW +: PW] !== 8'h7f || overflow_s[4] !== 1'b1) begin
         errors++; $display("FAIL overflow_sat: got %h/%b want 7f/1", pos_s[4*PW +: PW],
                            overflow_s[4]);
      end
      pulse(4, 1'b1, 1);
      checks++;
      if (pos_s[4*PW +: PW] !== 8'h7e || pos[4*PW +: PW] !== 8'h7f) begin
         errors++; $display("FAIL overflow_back: got sat=%h wrap=%h want 7e/7f",
                            pos_s[4*PW +: PW], pos[4*PW +: PW]);
      end
   endtask

   task automatic test_limits_snapshot();
      lim_min[3*PW +: PW] = 8'hfe;
      lim_max[3*PW +: PW] = 8'd3;
      pulse(3, 1'b0, 2);
      stepper_step[3] = 1'b1; tick();
      stepper_step[3] = 1'b0;
      for (int k = 0; k < 6 && pos[3*PW +: PW] != 8'd3; k++) tick();
      checks++;
      if (pos[3*PW +: PW] !== 8'd3 || at_max[3] !== 1'b0) begin
         errors++; $display("FAIL limit_pre: got pos=%0d at_max=%b want 3/0", pos[3*PW +: PW],
                            at_max[3]);
      end
      tick();
      checks++;
      if (at_max[3] !== 1'b1 || at_min[3] !== 1'b0) begin
         errors++; $display("FAIL limit_max: got %b/%b want 1/0", at_max[3], at_min[3]);
      end
      stepper_step[0] = 1'b1;
      tick(); tick();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      stepper_step[0] = 1'b0;
      checks++;
      if (snap_valid !== 1'b1 || snap_pos !== pack(m_snap) || snap_pos[0 +: PW] !== 8'd101) begin
         errors++; $display("FAIL snap_capture: got v=%b %h want 1 %h", snap_valid, snap_pos,
                            pack(m_snap));
      end
      tick();
      checks++;
      if (snap_valid !== 1'b0 || snap_pos_s !== pack(m_snap_sat)) begin
         errors++; $display("FAIL snap_hold: got v=%b %h want 0 %h", snap_valid, snap_pos_s,
                            pack(m_snap_sat));
      end
   endtask

   task automatic test_back_to_back();
      snap_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         stepper_step[1] = k[0];
         tick();
         checks++;
         if (snap_valid !== 1'b1 || snap_pos !== pack(m_snap)) begin
            errors++; $display("FAIL b2b_snap: got v=%b %h want 1 %h", snap_valid, snap_pos,
                               pack(m_snap));
         end
      end
      snap_req = 1'b0;
      stepper_step[1] = 1'b0;
      tick();
      checks++;
      if (snap_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end: got %b want 0", snap_valid);
      end
   endtask

   task automatic test_reset_mid();
      stepper_step[2] = 1'b1;
      tick();
      stepper_step[2] = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({pos, pos_s, snap_pos, at_min, at_max, step_lost, overflow, overflow_s, snap_valid}
          !== '0) begin
         errors++; $display("FAIL reset_mid: got %h want 0", {pos, pos_s, snap_pos, at_min,
                            at_max, step_lost, overflow, overflow_s, snap_valid});
      end
      model_reset();
      #1 reset = 1'b0;
      repeat (6) tick();
      checks++;
      if (pos !== '0 || pos_s !== '0) begin
         errors++; $display("FAIL reset_phantom: got %h/%h want 0", pos, pos_s);
      end
   endtask

   task automatic test_random();
      int sel;
      for (int c = 0; c < 600; c++) begin
         stepper_step = NA'($urandom);
         if ($urandom_range(0, 3) == 0) stepper_direction = NA'($urandom);
         if ($urandom_range(0, 7) == 0) stepper_enable = NA'($urandom) & NA'($urandom);
         set_new_coordinates = '0;
         for (int i = 0; i < NA; i++) begin
            if ($urandom_range(0, 15) == 0) set_new_coordinates[i] = 1'b1;
            sel = $urandom_range(0, 4);
            new_pos[i*PW +: PW] = (sel == 0) ? 8'h7f : (sel == 1) ? 8'h80 :
                                  (sel == 2) ? 8'h7e : (sel == 3) ? 8'h81 : 8'($urandom);
            if ($urandom_range(0, 31) == 0) lim_min[i*PW +: PW] = 8'($urandom);
            if ($urandom_range(0, 31) == 0) lim_max[i*PW +: PW] = 8'($urandom);
         end
         clear_flags = ($urandom_range(0, 7) == 0);
         snap_req = ($urandom_range(0, 3) == 0);
         tick();
         checks++;
         if (pos !== pack(m_pos) || pos_s !== pack(m_sat)) begin
            errors++; $display("FAIL rand_pos c=%0d: got %h/%h want %h/%h", c, pos, pos_s,
                               pack(m_pos), pack(m_sat));
         end
         checks++;
         if (at_min !== m_amin || at_max !== m_amax || at_min_s !== m_amin_s ||
             at_max_s !== m_amax_s) begin
            errors++; $display("FAIL rand_limits c=%0d: got %b %b %b %b want %b %b %b %b", c,
                               at_min, at_max, at_min_s, at_max_s, m_amin, m_amax, m_amin_s,
                               m_amax_s);
         end
         checks++;
         if (step_lost !== m_lost || step_lost_s !== m_lost || overflow !== m_ovf ||
             overflow_s !== m_ovf_s) begin
            errors++; $display("FAIL rand_flags c=%0d: got %b %b %b %b want %b %b %b", c,
                               step_lost, step_lost_s, overflow, overflow_s, m_lost, m_ovf,
                               m_ovf_s);
         end
         checks++;
         if (snap_valid !== m_sv || snap_valid_s !== m_sv || snap_pos !== pack(m_snap) ||
             snap_pos_s !== pack(m_snap_sat)) begin
            errors++; $display("FAIL rand_snap c=%0d: got %b %h %h want %b %h %h", c, snap_valid,
                               snap_pos, snap_pos_s, m_sv, pack(m_snap), pack(m_snap_sat));
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      stepper_enable = '0;
      stepper_step = '0;
      stepper_direction = '0;
      set_new_coordinates = '0;
      new_pos = '0;
      lim_min = '0;
      lim_max = '0;
      clear_flags = 1'b0;
      snap_req = 1'b0;
      model_reset();
      test_reset();
      test_count();
      test_enable();
      test_collision();
      test_overflow();
      test_limits_snapshot();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
